// File: rtl/wb_write_arbiter.sv
// ---------------------------------------------------------------------------
// wb_write_arbiter
//
// Writeback arbiter and queue in front of the single register-file write
// port. Two producers (port A: ALU, port B: load/multiply unit) are merged
// into a DEPTH-entry FIFO. The FIFO retires one write per cycle, because the
// register file always accepts. A drained flag reports that, once halted,
// every pending write has landed, so a register dump can follow safely.
//
// Optional feature macro: WB_FWD_EN
//   When defined, two lookup ports report whether a register index is still
//   pending in the FIFO, and return the data of the youngest matching entry.
//   When undefined, the hit/data outputs are tied to 0 and no compare logic
//   is built.
//
// Parameters
//   XLEN   data width (matches the register file)
//   DEPTH  FIFO entries, power of 2, >= 2
//
// Ports
//   clk, rst_b                 clock, asynchronous active-low reset
//   a_valid/a_ready/a_rd/a_data  port A write request
//   b_valid/b_ready/b_rd/b_data  port B write request
//   rd_we/rd_num/rd_data       register-file write port (FIFO head)
//   halted                     stop accepting, keep draining
//   drained                    halted and FIFO empty
//   count                      current FIFO occupancy
//   rs1_num/rs2_num            forwarding lookup indices
//   rs1_fwd_hit/rs1_fwd_data   forwarding result for rs1_num
//   rs2_fwd_hit/rs2_fwd_data   forwarding result for rs2_num
// ---------------------------------------------------------------------------
module wb_write_arbiter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [4:0]               a_rd,
    input  logic [XLEN-1:0]          a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [4:0]               b_rd,
    input  logic [XLEN-1:0]          b_data,
    output logic                     rd_we,
    output logic [4:0]               rd_num,
    output logic [XLEN-1:0]          rd_data,
    input  logic                     halted,
    output logic                     drained,
    output logic [$clog2(DEPTH):0]   count,
    input  logic [4:0]               rs1_num,
    input  logic [4:0]               rs2_num,
    output logic                     rs1_fwd_hit,
    output logic [XLEN-1:0]          rs1_fwd_data,
    output logic                     rs2_fwd_hit,
    output logic [XLEN-1:0]          rs2_fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // FIFO state
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             last_b_reg;
    logic [4:0]       rd_mem   [DEPTH];
    logic [XLEN-1:0]  data_mem [DEPTH];

    logic             empty;
    logic             full;
    logic             grant_a;
    logic             grant_b;
    logic             accept_a;
    logic             accept_b;
    logic             accept;
    logic [4:0]       push_rd;
    logic [XLEN-1:0]  push_data;
    logic             push;
    logic             pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(DEPTH));

    // Arbitration. A lone valid port always wins; with both valid, last_b
    // decides (B when last_b is 0). With no port valid both grants stay high
    // so ready simply reflects !full && !halted.
    always_comb begin
        grant_a = 1'b1;
        grant_b = 1'b1;
        if (a_valid && b_valid) begin
            grant_a = last_b_reg;
            grant_b = !last_b_reg;
        end else if (a_valid) begin
            grant_b = 1'b0;
        end else if (b_valid) begin
            grant_a = 1'b0;
        end
    end

    // Ready ignores the same-cycle pop: a full FIFO blocks for this cycle
    // even though the head is retiring.
    assign a_ready = !full && !halted && grant_a;
    assign b_ready = !full && !halted && grant_b;

    assign accept_a = a_valid && a_ready;
    assign accept_b = b_valid && b_ready;
    assign accept   = accept_a || accept_b;

    assign push_rd   = accept_b ? b_rd   : a_rd;
    assign push_data = accept_b ? b_data : a_data;

    // Writes to x0 complete the handshake but never occupy a slot.
    assign push = accept && (push_rd != 5'd0);
    assign pop  = !empty;

    assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            head_reg   <= '0;
            tail_reg   <= '0;
            count_reg  <= '0;
            last_b_reg <= 1'b0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            count_reg <= count_next;
            if (accept) begin
                last_b_reg <= accept_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
        end else if (push) begin
            rd_mem[tail_reg]   <= push_rd;
            data_mem[tail_reg] <= push_data;
        end
    end

    // Output side: head shown combinationally, zeroed when empty.
    assign rd_we   = !empty;
    assign rd_num  = empty ? 5'd0      : rd_mem[head_reg];
    assign rd_data = empty ? {XLEN{1'b0}} : data_mem[head_reg];
    assign count   = count_reg;

    // drained is forced low while reset is held, even if halted is high.
    assign drained = rst_b && halted && empty;

`ifdef WB_FWD_EN
    // Slots listed by age: age 0 is the head (oldest), age count-1 the
    // youngest. Scanning oldest to youngest and letting later matches
    // overwrite yields the youngest matching data.
    logic [PTR_W-1:0] slot_idx  [DEPTH];
    logic             slot_live [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign slot_idx[gi]  = head_reg + PTR_W'(gi);
        assign slot_live[gi] = (CNT_W'(gi) < count_reg);
    end

    always_comb begin
        rs1_fwd_hit  = 1'b0;
        rs1_fwd_data = '0;
        rs2_fwd_hit  = 1'b0;
        rs2_fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (slot_live[k] && (rs1_num != 5'd0) && (rd_mem[slot_idx[k]] == rs1_num)) begin
                rs1_fwd_hit  = 1'b1;
                rs1_fwd_data = data_mem[slot_idx[k]];
            end
            if (slot_live[k] && (rs2_num != 5'd0) && (rd_mem[slot_idx[k]] == rs2_num)) begin
                rs2_fwd_hit  = 1'b1;
                rs2_fwd_data = data_mem[slot_idx[k]];
            end
        end
    end
`else
    // Lookup indices are intentionally ignored in this build.
    logic unused_fwd;
    assign unused_fwd   = ^{rs1_num, rs2_num};
    assign rs1_fwd_hit  = 1'b0;
    assign rs1_fwd_data = '0;
    assign rs2_fwd_hit  = 1'b0;
    assign rs2_fwd_data = '0;
`endif

endmodule
